// File: rtl/multi_lane_spi_master_if.sv
// rtl/multi_lane_spi_master_if.sv - request/handshake bus between the register sequencer and the SPI master
interface multi_lane_spi_master_if #(
    parameter int DATA_W = 64,
    parameter int DIV_W  = 8,
    parameter int CNT_W  = 7
);
    logic              start;
    logic [1:0]        lane_mode;
    logic [CNT_W-1:0]  nbits;
    logic [DIV_W-1:0]  clk_div;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic              err;

    modport master (output start, lane_mode, nbits, clk_div, data_in,
                    input  busy, done, err);
    modport slave  (input  start, lane_mode, nbits, clk_div, data_in,
                    output busy, done, err);
endinterface

// File: rtl/multi_lane_spi_master.sv
// rtl/multi_lane_spi_master.sv - 1/2/4-lane MSB-first SPI master for the AD9958 serial port
module multi_lane_spi_master #(
    parameter int DATA_W = 64,
    parameter int DIV_W  = 8,
    parameter int CNT_W  = 7
) (
    input  logic                          clock,
    input  logic                          reset_n,
    multi_lane_spi_master_if.slave        req,
    output logic                          cs_n,
    output logic                          sclk,
    output logic [3:0]                    sdio,
    output logic [3:0]                    sdio_oe
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    logic [2:0]        state;
    logic [DIV_W-1:0]  div_cnt, div_q;
    logic [CNT_W-1:0]  edge_cnt, nbits_q, groups, next_edge, lane_cnt_in;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] shreg, aligned;
    logic              err_q, half_done, last_gap, accept, req_ok;

    function automatic logic [3:0] lane_group(input logic [DATA_W-1:0] v, input logic [1:0] m);
        case (m)
            2'd0:    return {3'b000, v[DATA_W-1]};
            2'd1:    return {2'b00, v[DATA_W-1 -: 2]};
            default: return v[DATA_W-1 -: 4];
        endcase
    endfunction

    function automatic logic [3:0] lane_oe(input logic [1:0] m);
        case (m)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] lane_shift(input logic [1:0] m);
        case (m)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign half_done = (div_cnt == div_q);
    assign groups    = nbits_q >> mode_q;
    assign next_edge = edge_cnt + CNT_W'(1);
    assign last_gap  = (state == GAP) && half_done;
    assign req.done  = last_gap;
    assign req.busy  = (state != IDLE) && !last_gap;
    assign req.err   = err_q;
    assign accept    = req.start && !req.busy;
    // Left-justify the payload so the first bit to send is always the MSB of the shifter.
    assign aligned   = req.data_in << (CNT_W'(DATA_W) - req.nbits);

    always_comb begin
        lane_cnt_in = CNT_W'(1) << req.lane_mode;
        req_ok = (req.nbits != '0) && (req.nbits <= CNT_W'(DATA_W)) &&
                 (req.lane_mode != 2'd3) &&
                 ((req.nbits & (lane_cnt_in - CNT_W'(1))) == '0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            div_q    <= '0;
            edge_cnt <= '0;
            nbits_q  <= '0;
            mode_q   <= 2'd0;
            shreg    <= '0;
            err_q    <= 1'b0;
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            sdio     <= 4'b0000;
            sdio_oe  <= 4'b0000;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: ;
                GAP: begin
                    if (half_done) state <= IDLE;
                    else           div_cnt <= div_cnt + DIV_W'(1);
                end
                SETUP: begin
                    if (half_done) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        sclk    <= !sclk;
                        if (!sclk) begin
                            edge_cnt <= next_edge;
                            if (next_edge == groups) state <= HOLD;
                        end else begin
                            sdio  <= lane_group(shreg, mode_q);
                            shreg <= shreg << lane_shift(mode_q);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (sclk) begin
                            sclk <= 1'b0;
                        end else begin
                            state   <= GAP;
                            cs_n    <= 1'b1;
                            sdio    <= 4'b0000;
                            sdio_oe <= 4'b0000;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            // accept is only possible in IDLE or the final GAP cycle, so it overrides the above.
            if (accept) begin
                if (req_ok) begin
                    state    <= SETUP;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    div_q    <= req.clk_div;
                    nbits_q  <= req.nbits;
                    mode_q   <= req.lane_mode;
                    cs_n     <= 1'b0;
                    sdio     <= lane_group(aligned, req.lane_mode);
                    sdio_oe  <= lane_oe(req.lane_mode);
                    shreg    <= aligned << lane_shift(req.lane_mode);
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_lane_spi_master.sv
// tb/tb_multi_lane_spi_master.sv - directed self-checking bench for multi_lane_spi_master
module tb_multi_lane_spi_master;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       cs_n, sclk;
    logic [3:0] sdio, sdio_oe;
    int         checks = 0;
    int         errors = 0;

    multi_lane_spi_master_if bus();

    multi_lane_spi_master dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (bus),
        .cs_n    (cs_n),
        .sclk    (sclk),
        .sdio    (sdio),
        .sdio_oe (sdio_oe)
    );

    always #5 clock = ~clock;

    int         cyc = 0;
    int         cs_low = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
    logic       sclk_prev = 1'b0;
    logic [3:0] rise_q[$];
    logic [3:0] rise_oe[$];
    int         rise_cyc[$];

    always @(negedge clock) begin
        cyc++;
        if (!cs_n) cs_low++;
        if (bus.done) done_cnt++;
        if (bus.err) err_cnt++;
        if (bus.busy) busy_cnt++;
        if (sclk && !sclk_prev) begin
            rise_q.push_back(sdio);
            rise_oe.push_back(sdio_oe);
            rise_cyc.push_back(cyc);
        end
        sclk_prev = sclk;
    end

    task automatic clear_mon();
        @(negedge clock);
        cs_low = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        rise_q.delete(); rise_oe.delete(); rise_cyc.delete();
    endtask

    task automatic send(input logic [1:0] m, input logic [6:0] n, input logic [7:0] d, input logic [63:0] v);
        @(negedge clock);
        bus.start = 1'b1; bus.lane_mode = m; bus.nbits = n; bus.clk_div = d; bus.data_in = v;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (bus.done) break;
            @(negedge clock);
        end
        checks++;
        if (i >= 3000) begin
            errors++;
            $display("FAIL %s: done timeout, observed no done, expected done within 3000 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b0; bus.lane_mode = 2'd0; bus.nbits = '0; bus.clk_div = '0; bus.data_in = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if ({cs_n, sclk} !== 2'b10) begin errors++; $display("FAIL reset_cs_sclk: got %b expected 10", {cs_n, sclk}); end
        checks++; if ({sdio, sdio_oe} !== 8'h00) begin errors++; $display("FAIL reset_sdio: got %h expected 00", {sdio, sdio_oe}); end
    endtask

    task automatic test_four_lane();
        logic [15:0] e;
        e = 16'hA5C3;
        clear_mon();
        send(2'd2, 7'd16, 8'd0, 64'hA5C3);
        wait_done("t1");
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t1_busy_at_done: got %b expected 0", bus.busy); end
        repeat (3) @(negedge clock);
        checks++; if (rise_q.size() != 4) begin errors++; $display("FAIL t1_edges: got %0d expected 4", rise_q.size()); end
        for (int i = 0; i < 4 && i < rise_q.size(); i++) begin
            checks++;
            if (rise_q[i] !== e[15-4*i -: 4]) begin errors++; $display("FAIL t1_nibble%0d: got %h expected %h", i, rise_q[i], e[15-4*i -: 4]); end
        end
        checks++; if (cs_low != 10) begin errors++; $display("FAIL t1_cs_low: got %0d expected 10", cs_low); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL t1_done: got %0d expected 1", done_cnt); end
        checks++; if (rise_oe.size() > 0 && rise_oe[0] !== 4'hF) begin errors++; $display("FAIL t1_oe: got %b expected 1111", rise_oe[0]); end
    endtask

    task automatic test_one_lane();
        logic [7:0] e;
        e = 8'h81;
        clear_mon();
        send(2'd0, 7'd8, 8'd3, 64'h81);
        wait_done("t2");
        repeat (3) @(negedge clock);
        checks++; if (rise_q.size() != 8) begin errors++; $display("FAIL t2_edges: got %0d expected 8", rise_q.size()); end
        for (int i = 0; i < 8 && i < rise_q.size(); i++) begin
            checks++;
            if (rise_q[i] !== {3'b000, e[7-i]}) begin errors++; $display("FAIL t2_bit%0d: got %b expected %b", i, rise_q[i], {3'b000, e[7-i]}); end
            checks++;
            if (rise_oe[i] !== 4'b0001) begin errors++; $display("FAIL t2_oe%0d: got %b expected 0001", i, rise_oe[i]); end
            if (i > 0) begin
                checks++;
                if (rise_cyc[i] - rise_cyc[i-1] != 8) begin errors++; $display("FAIL t2_spacing%0d: got %0d expected 8", i, rise_cyc[i] - rise_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_two_lane();
        logic [63:0] recon;
        bit          upper_ok;
        recon = '0;
        upper_ok = 1'b1;
        clear_mon();
        send(2'd1, 7'd64, 8'd1, 64'h0123_4567_89AB_CDEF);
        wait_done("t3");
        repeat (3) @(negedge clock);
        checks++; if (rise_q.size() != 32) begin errors++; $display("FAIL t3_edges: got %0d expected 32", rise_q.size()); end
        foreach (rise_q[i]) begin
            recon = {recon[61:0], rise_q[i][1:0]};
            if (rise_q[i][3:2] !== 2'b00 || rise_oe[i] !== 4'b0011) upper_ok = 1'b0;
        end
        checks++; if (recon !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL t3_data: got %h expected 0123456789abcdef", recon); end
        checks++; if (!upper_ok) begin errors++; $display("FAIL t3_lanes: got upper lanes driven or oe wrong, expected sdio[3:2]=0 oe=0011"); end
        if (rise_q.size() == 32) begin
            checks++; if (rise_q[0][1:0] !== 2'b00) begin errors++; $display("FAIL t3_first: got %b expected 00", rise_q[0][1:0]); end
            checks++; if (rise_q[31][1:0] !== 2'b11) begin errors++; $display("FAIL t3_last: got %b expected 11", rise_q[31][1:0]); end
        end
    endtask

    task automatic test_rejects();
        logic [1:0] modes [4];
        logic [6:0] lens  [4];
        modes = '{2'd2, 2'd0, 2'd3, 2'd0};
        lens  = '{7'd6, 7'd0, 7'd8, 7'd65};
        clear_mon();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            bus.start = 1'b1; bus.lane_mode = modes[k]; bus.nbits = lens[k]; bus.clk_div = 8'd0; bus.data_in = 64'hFF;
            @(negedge clock);
            bus.start = 1'b0;
            checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL t4_err%0d: got %b expected 1", k, bus.err); end
            @(negedge clock);
            checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL t4_err_pulse%0d: got %b expected 0", k, bus.err); end
        end
        repeat (2) @(negedge clock);
        checks++; if (cs_low != 0) begin errors++; $display("FAIL t4_cs: got %0d low cycles expected 0", cs_low); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL t4_busy: got %0d busy cycles expected 0", busy_cnt); end
        checks++; if (err_cnt != 4) begin errors++; $display("FAIL t4_err_count: got %0d expected 4", err_cnt); end
    endtask

    task automatic test_reset_mid();
        int i;
        logic [15:0] e;
        e = 16'h5A0F;
        clear_mon();
        send(2'd2, 7'd32, 8'd1, 64'hDEAD_BEEF);
        for (i = 0; i < 500; i++) begin
            if (rise_q.size() >= 5) break;
            @(negedge clock);
        end
        checks++; if (i >= 500) begin errors++; $display("FAIL t5_wait: got %0d edges expected 5", rise_q.size()); end
        checks++; if (rise_q.size() >= 5 && rise_q[4] !== 4'hB) begin errors++; $display("FAIL t5_fifth: got %h expected b", rise_q[4]); end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checks++; if ({cs_n, sclk, sdio_oe, bus.busy} !== 7'b1000000) begin errors++; $display("FAIL t5_abort: got %b expected 1000000", {cs_n, sclk, sdio_oe, bus.busy}); end
        repeat (10) @(negedge clock);
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL t5_no_done: got %0d expected 0", done_cnt); end
        clear_mon();
        send(2'd2, 7'd16, 8'd0, 64'h5A0F);
        wait_done("t5_restart");
        repeat (3) @(negedge clock);
        checks++; if (rise_q.size() != 4) begin errors++; $display("FAIL t5_restart_edges: got %0d expected 4", rise_q.size()); end
        for (int k = 0; k < 4 && k < rise_q.size(); k++) begin
            checks++;
            if (rise_q[k] !== e[15-4*k -: 4]) begin errors++; $display("FAIL t5_restart_nibble%0d: got %h expected %h", k, rise_q[k], e[15-4*k -: 4]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        e = 32'h1234_2310;
        clear_mon();
        @(negedge clock);
        bus.start = 1'b1; bus.lane_mode = 2'd2; bus.nbits = 7'd16; bus.clk_div = 8'd0; bus.data_in = 64'h1234;
        @(negedge clock);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL t6_busy: got %b expected 1", bus.busy); end
        bus.lane_mode = 2'd1; bus.nbits = 7'd8; bus.data_in = 64'hB4;
        wait_done("t6_first");
        @(negedge clock);
        checks++; if ({cs_n, bus.busy} !== 2'b01) begin errors++; $display("FAIL t6_second_start: got cs_n,busy=%b expected 01", {cs_n, bus.busy}); end
        bus.start = 1'b0;
        wait_done("t6_second");
        repeat (3) @(negedge clock);
        checks++; if (rise_q.size() != 8) begin errors++; $display("FAIL t6_edges: got %0d expected 8", rise_q.size()); end
        for (int k = 0; k < 8 && k < rise_q.size(); k++) begin
            checks++;
            if (rise_q[k] !== e[31-4*k -: 4]) begin errors++; $display("FAIL t6_group%0d: got %h expected %h", k, rise_q[k], e[31-4*k -: 4]); end
        end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL t6_done: got %0d expected 2", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_four_lane();
        test_one_lane();
        test_two_lane();
        test_rejects();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
